cache_port_arbiter: RTL and testbench
=====================================

// Module: cache_port_arbiter
// PURPOSE
// - Shares one tiny cache between two requesters (port A, port B) with round-robin arbitration.
// - Sequences each accepted request: cache lookup, read-miss fill from backing memory, and write-through to memory.
// - Sits between the two requesters and the cache datapath; owns the only memory-side handshake.
// PARAMETERS
// - ADDR_W    2   request/cache/memory address width
// - DATA_W    2   data width
// - CACHE_LAT 1   cycles from c_valid pulse to c_hit/c_rdata valid (>=1)
// PORTS
// - clk        in   1       clock
// - rst_n      in   1       reset, asynchronous, active-low
// - a_valid    in   1       port A request valid; a_rw/a_addr/a_wdata held stable while high
// - a_rw       in   1       1=write, 0=read
// - a_addr     in   ADDR_W  request address
// - a_wdata    in   DATA_W  write data
// - a_ready    out  1       port A request accepted this cycle (a_valid & a_ready)
// - b_valid, b_rw, b_addr, b_wdata, b_ready: same as port A, for port B
// - resp_valid out  1       one-cycle response pulse; no backpressure
// - resp_id    out  1       0=port A, 1=port B
// - resp_hit   out  1       cache lookup hit
// - resp_data  out  DATA_W  read data (0 for writes)
// - c_valid    out  1       one-cycle cache access strobe
// - c_rw       out  1       cache access type
// - c_addr     out  ADDR_W  cache address
// - c_wdata    out  DATA_W  cache write data
// - c_hit      in   1       cache hit, valid CACHE_LAT cycles after c_valid
// - c_rdata    in   DATA_W  cache read data, same timing as c_hit
// - mem_req    out  1       memory request; held until mem_ack
// - mem_we     out  1       1=write-through, 0=read fill
// - mem_addr   out  ADDR_W  memory address
// - mem_wdata  out  DATA_W  memory write data
// - mem_ack    in   1       completes mem_req this cycle; mem_rdata valid with it
// - mem_rdata  in   DATA_W  memory read data
// - miss_cnt   out  8       saturating count of lookup misses (reads and writes)
// BEHAVIOUR
// - Reset: FSM=IDLE; all outputs 0; miss_cnt=0; rr pointer favours port A.
// - Async reset mid-transaction aborts it: no resp_valid, mem_req drops immediately.
// - FSM: IDLE -> LOOKUP -> WAIT -> (read hit | write miss/hit) ...
//   - IDLE: if any valid, assert ready of the granted port (combinational, IDLE only).
//     Latch rw/addr/wdata/id; go LOOKUP.
//   - LOOKUP: c_valid=1 for one cycle with the latched request; go WAIT.
//   - WAIT: count CACHE_LAT cycles, then sample c_hit/c_rdata; miss increments miss_cnt (sticks at 255).
//     - read hit: go RESP, data=c_rdata.
//     - read miss: go MEM.
//     - write (hit or miss): go MEM.
//   - MEM: mem_req=1 with mem_we=rw until mem_ack (ack may arrive in first MEM cycle).
//     Read goes FILL, capturing mem_rdata; write goes RESP.
//   - FILL: c_valid=1, c_rw=1, c_wdata=captured data, one cycle; go RESP.
//   - RESP: resp_valid=1 one cycle with id/hit/data; go IDLE.
// - Arbitration: both valid, grant the port not granted last; one valid, grant it.
//   Pointer updates only on acceptance.
// - One request outstanding max; requesters see ready=0 outside IDLE.
// - Min latency accept->resp_valid: read hit 2+CACHE_LAT cycles.
// - mem_* outputs 0 outside MEM; c_* outputs 0 outside LOOKUP/FILL.
// STRUCTURE
// - Shared package: FSM state enum, PORT_A/PORT_B id constants, MISS_CNT_W=8.
// - Sub-module rr_arb2: 2-way round-robin grant with pointer register; rest stays in the top FSM.
// TESTING
// - Reset, then port A read addr=1: miss (c_hit=0), mem_ack data=2 after 3 cycles -> FILL writes 2;
//   resp id=0 hit=0 data=2; miss_cnt=1.
// - Repeat A read addr=1 with c_hit=1,c_rdata=2 -> resp hit=1 data=2 three cycles after accept; no mem_req.
// - A and B valid together for 4 requests -> grants A,B,A,B; resp_id matches; never both ready.
// - B write addr=3 data=1 -> c_valid c_rw=1; then mem_req mem_we=1 addr=3 data=1 held 2 cycles until ack;
//   resp id=1.
// - Assert rst_n=0 while mem_req high -> mem_req/resp_valid/ready 0 immediately; next request served normally.
// - Force 300 misses -> miss_cnt saturates at 255, does not wrap.

Source files
------------

// File: rtl/cache_port_arbiter_pkg.sv
// Shared types and constants for the two-port cache arbiter.
package cache_port_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WAIT,
        ST_MEM,
        ST_FILL,
        ST_RESP
    } state_e;

    localparam logic PORT_A     = 1'b0;
    localparam logic PORT_B     = 1'b1;
    localparam int   MISS_CNT_W = 8;

endpackage

// File: rtl/cache_port_arbiter_rr_arb2.sv
// Two-way round-robin grant; the pointer remembers the last granted port.
module cache_port_arbiter_rr_arb2
    import cache_port_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic req_a_i,
    input  logic req_b_i,
    output logic gnt_valid_o,
    output logic gnt_id_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt_id_o = PORT_A;
        if (req_a_i && req_b_i) begin
            gnt_id_o = ~last_q;
        end else if (req_b_i) begin
            gnt_id_o = PORT_B;
        end
        gnt_valid_o = en_i && (req_a_i || req_b_i);
        last_d      = gnt_valid_o ? gnt_id_o : last_q;
    end

    // Reset as if B went last so A wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= PORT_B;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/cache_port_arbiter.sv
// Two-port cache front end: round-robin accept, cache lookup, read-miss fill
// and write-through to backing memory, one request in flight.
module cache_port_arbiter
    import cache_port_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 2,
    parameter int DATA_W    = 2,
    parameter int CACHE_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_valid,
    input  logic                  a_rw,
    input  logic [ADDR_W-1:0]     a_addr,
    input  logic [DATA_W-1:0]     a_wdata,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic                  b_rw,
    input  logic [ADDR_W-1:0]     b_addr,
    input  logic [DATA_W-1:0]     b_wdata,
    output logic                  b_ready,
    output logic                  resp_valid,
    output logic                  resp_id,
    output logic                  resp_hit,
    output logic [DATA_W-1:0]     resp_data,
    output logic                  c_valid,
    output logic                  c_rw,
    output logic [ADDR_W-1:0]     c_addr,
    output logic [DATA_W-1:0]     c_wdata,
    input  logic                  c_hit,
    input  logic [DATA_W-1:0]     c_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic [MISS_CNT_W-1:0] miss_cnt
);

    // state  | meaning
    // IDLE   | grant a port, latch its request
    // LOOKUP | one-cycle cache strobe with the latched request
    // WAIT   | count CACHE_LAT cycles, then sample hit/data
    // MEM    | read fill or write-through, held until ack
    // FILL   | write fetched data into the cache
    // RESP   | one-cycle response pulse

    localparam int LAT_W = (CACHE_LAT > 1) ? $clog2(CACHE_LAT) : 1;

    state_e                  state_q, state_d;
    logic                    run_q;
    logic                    rw_q, rw_d;
    logic                    id_q, id_d;
    logic                    hit_q, hit_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic [DATA_W-1:0]       data_q, data_d;
    logic [LAT_W-1:0]        lat_q, lat_d;
    logic [MISS_CNT_W-1:0]   miss_q, miss_d;
    logic                    arb_en;
    logic                    gnt_valid;
    logic                    gnt_id;

    // run_q keeps ready low while reset is asserted.
    assign arb_en   = (state_q == ST_IDLE) && run_q;
    assign miss_cnt = miss_q;

    cache_port_arbiter_rr_arb2 u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (arb_en),
        .req_a_i     (a_valid),
        .req_b_i     (b_valid),
        .gnt_valid_o (gnt_valid),
        .gnt_id_o    (gnt_id)
    );

    always_comb begin
        state_d    = state_q;
        rw_d       = rw_q;
        id_d       = id_q;
        hit_d      = hit_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        data_d     = data_q;
        lat_d      = lat_q;
        miss_d     = miss_q;
        a_ready    = 1'b0;
        b_ready    = 1'b0;
        resp_valid = 1'b0;
        resp_id    = 1'b0;
        resp_hit   = 1'b0;
        resp_data  = '0;
        c_valid    = 1'b0;
        c_rw       = 1'b0;
        c_addr     = '0;
        c_wdata    = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;

        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    a_ready = (gnt_id == PORT_A);
                    b_ready = (gnt_id == PORT_B);
                    id_d    = gnt_id;
                    rw_d    = (gnt_id == PORT_B) ? b_rw    : a_rw;
                    addr_d  = (gnt_id == PORT_B) ? b_addr  : a_addr;
                    wdata_d = (gnt_id == PORT_B) ? b_wdata : a_wdata;
                    data_d  = '0;
                    hit_d   = 1'b0;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                c_valid = 1'b1;
                c_rw    = rw_q;
                c_addr  = addr_q;
                c_wdata = rw_q ? wdata_q : '0;
                lat_d   = LAT_W'(CACHE_LAT - 1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (lat_q == '0) begin
                    hit_d = c_hit;
                    if (!c_hit && (miss_q != '1)) begin
                        miss_d = miss_q + 1'b1;
                    end
                    if (!rw_q && c_hit) begin
                        data_d  = c_rdata;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_MEM;
                    end
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            ST_MEM: begin
                mem_req   = 1'b1;
                mem_we    = rw_q;
                mem_addr  = addr_q;
                mem_wdata = rw_q ? wdata_q : '0;
                if (mem_ack) begin
                    if (rw_q) begin
                        state_d = ST_RESP;
                    end else begin
                        data_d  = mem_rdata;
                        state_d = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                c_valid = 1'b1;
                c_rw    = 1'b1;
                c_addr  = addr_q;
                c_wdata = data_q;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_id    = id_q;
                resp_hit   = hit_q;
                resp_data  = rw_q ? '0 : data_q;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            run_q   <= 1'b0;
            rw_q    <= 1'b0;
            id_q    <= PORT_A;
            hit_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            lat_q   <= '0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            rw_q    <= rw_d;
            id_q    <= id_d;
            hit_q   <= hit_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            lat_q   <= lat_d;
            miss_q  <= miss_d;
        end
    end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Scoreboard bench: bench-side cache and memory, reference model of coherent
// read data, hit history, miss count and round-robin order.
module tb_cache_port_arbiter;
    import cache_port_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a_valid = 1'b0, a_rw = 1'b0;
    logic [1:0] a_addr = '0, a_wdata = '0;
    logic       a_ready;
    logic       b_valid = 1'b0, b_rw = 1'b0;
    logic [1:0] b_addr = '0, b_wdata = '0;
    logic       b_ready;
    logic       resp_valid, resp_id, resp_hit;
    logic [1:0] resp_data;
    logic       c_valid, c_rw;
    logic [1:0] c_addr, c_wdata;
    logic       c_hit = 1'b0;
    logic [1:0] c_rdata = '0;
    logic       mem_req, mem_we;
    logic [1:0] mem_addr, mem_wdata;
    logic       mem_ack = 1'b0;
    logic [1:0] mem_rdata = '0;
    logic [7:0] miss_cnt;

    cache_port_arbiter #(.ADDR_W(2), .DATA_W(2), .CACHE_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_rw(a_rw), .a_addr(a_addr), .a_wdata(a_wdata), .a_ready(a_ready),
        .b_valid(b_valid), .b_rw(b_rw), .b_addr(b_addr), .b_wdata(b_wdata), .b_ready(b_ready),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_hit(resp_hit), .resp_data(resp_data),
        .c_valid(c_valid), .c_rw(c_rw), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_hit(c_hit), .c_rdata(c_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { bit rw; bit [1:0] addr; bit [1:0] wdata; } req_t;
    typedef struct { bit id; bit hit; bit [1:0] data; int misses; bit mem_used; int acc_cyc; bit chk_lat; } exp_t;

    exp_t exp_q[$];
    req_t qa[$], qb[$];

    int total = 0, bad = 0;

    // reference model
    bit       seen[4];
    bit [1:0] val[4];
    int       m_misses;
    bit       m_last;
    // bench environment: cache array, backing memory, current transaction
    bit       cvld[4];
    bit [1:0] cdat[4];
    bit [1:0] mem[4];
    bit       rand_delay;
    int       fixed_delay;
    req_t     cur;
    bit [1:0] cur_data;
    bit       mem_seen;
    int       strobes;

    function automatic void check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic req_t mk(bit rw, bit [1:0] addr, bit [1:0] wdata);
        req_t r;
        r.rw = rw; r.addr = addr; r.wdata = wdata;
        return r;
    endfunction

    function automatic req_t rand_req();
        return mk(1'($urandom_range(0, 1)), 2'($urandom), 2'($urandom));
    endfunction

    function automatic void evict(int a);
        cvld[a] = 1'b0;
        cdat[a] = 2'($urandom);
        seen[a] = 1'b0;
    endfunction

    // Every access allocates, so an address hits iff touched since last eviction;
    // reads always return the most recent value written to that address.
    function automatic void model_accept(bit id, req_t r, int acc);
        exp_t e;
        e.id  = id;
        e.hit = seen[r.addr];
        if (!e.hit && m_misses < 255) m_misses++;
        if (r.rw) begin
            val[r.addr] = r.wdata;
            e.data = 2'd0;
        end else begin
            e.data = val[r.addr];
        end
        seen[r.addr] = 1'b1;
        e.misses   = m_misses;
        e.mem_used = r.rw || !e.hit;
        e.acc_cyc  = acc;
        e.chk_lat  = !r.rw && e.hit;
        m_last     = id;
        cur        = r;
        cur_data   = r.rw ? r.wdata : val[r.addr];
        mem_seen   = 1'b0;
        strobes    = 0;
        exp_q.push_back(e);
    endfunction

    // response monitor
    always @(negedge clk) begin
        if (rst_n && resp_valid) begin
            if (exp_q.size() == 0) begin
                check("resp_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("resp_id", resp_id, e.id);
                check("resp_hit", resp_hit, e.hit);
                check("resp_data", resp_data, e.data);
                check("miss_cnt", miss_cnt, e.misses);
                check("mem_used", mem_seen, e.mem_used);
                if (e.chk_lat) check("hit_latency", cyc - e.acc_cyc, 3);
            end
        end
    end

    // cache responder: result held from the strobe until the next one
    always @(negedge clk) begin
        if (rst_n && c_valid) begin
            if (strobes == 0) begin
                check("c_lookup_rw", c_rw, cur.rw);
                check("c_lookup_addr", c_addr, cur.addr);
                if (cur.rw) check("c_lookup_wdata", c_wdata, cur.wdata);
            end else if (strobes == 1) begin
                check("c_fill_rw", c_rw, 1);
                check("c_fill_addr", c_addr, cur.addr);
                check("c_fill_wdata", c_wdata, cur_data);
            end else begin
                check("c_extra_strobe", strobes, 1);
            end
            c_hit   = cvld[c_addr];
            c_rdata = cdat[c_addr];
            if (c_rw) begin
                cvld[c_addr] = 1'b1;
                cdat[c_addr] = c_wdata;
            end
            strobes++;
        end else if (rst_n) begin
            check("c_idle", {c_rw, c_addr, c_wdata}, 0);
        end
    end

    // memory responder
    int mcyc = 0, mdel = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            mem_ack = 1'b0;
            mcyc = 0;
        end else if (mem_ack) begin
            mem_ack = 1'b0;
            check("mem_req_drop", mem_req, 0);
        end else if (mem_req) begin
            if (mcyc == 0) mdel = rand_delay ? int'($urandom_range(0, 3)) : fixed_delay;
            mem_seen = 1'b1;
            check("mem_we", mem_we, cur.rw);
            check("mem_addr", mem_addr, cur.addr);
            if (cur.rw) check("mem_wdata", mem_wdata, cur.wdata);
            if (mcyc == mdel) begin
                mem_ack = 1'b1;
                mcyc = 0;
                if (mem_we) mem[mem_addr] = mem_wdata;
                else        mem_rdata = mem[mem_addr];
            end else begin
                mcyc++;
                mem_rdata = 2'($urandom);
            end
        end else begin
            check("mem_idle", {mem_we, mem_addr, mem_wdata}, 0);
        end
    end

    task automatic drive();
        int   budget;
        bit   gid, exp_id;
        req_t r;
        budget = 3000;
        while ((qa.size() > 0 || qb.size() > 0) && budget > 0) begin
            a_valid = (qa.size() > 0);
            if (a_valid) begin a_rw = qa[0].rw; a_addr = qa[0].addr; a_wdata = qa[0].wdata; end
            b_valid = (qb.size() > 0);
            if (b_valid) begin b_rw = qb[0].rw; b_addr = qb[0].addr; b_wdata = qb[0].wdata; end
            @(negedge clk);
            budget--;
            if (a_ready && b_ready) begin
                check("ready_exclusive", 1, 0);
            end else if (a_ready || b_ready) begin
                gid = b_ready;
                if (gid ? !b_valid : !a_valid) begin
                    check("ready_without_valid", 1, 0);
                end else begin
                    exp_id = (a_valid && b_valid) ? ~m_last : (b_valid ? PORT_B : PORT_A);
                    check("grant_id", gid, exp_id);
                    r = gid ? qb.pop_front() : qa.pop_front();
                    model_accept(gid, r, cyc);
                end
            end
            @(posedge clk); #1;
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        if (budget == 0) begin
            check("drive_timeout", qa.size() + qb.size(), 0);
            qa.delete();
            qb.delete();
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() > 0) begin
            check("resp_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int n;
        for (int i = 0; i < 4; i++) begin
            mem[i]  = 2'($urandom);
            val[i]  = mem[i];
            cvld[i] = 1'b0;
            cdat[i] = 2'($urandom);
            seen[i] = 1'b0;
        end
        mem[1] = 2'd2;
        val[1] = 2'd2;
        m_misses = 0;
        m_last = PORT_B;
        rand_delay = 1'b0;
        fixed_delay = 0;

        #1;
        check("rst_a_ready", a_ready, 0);
        check("rst_b_ready", b_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_c_valid", c_valid, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_miss_cnt", miss_cnt, 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // read miss, fill from memory after a delayed ack
        fixed_delay = 3;
        qa.push_back(mk(1'b0, 2'd1, 2'd0));
        drive(); drain();
        check("miss_after_fill", miss_cnt, m_misses);

        // same read now hits, no memory traffic
        qa.push_back(mk(1'b0, 2'd1, 2'd0));
        drive(); drain();

        // port B write-through, ack in second MEM cycle
        fixed_delay = 1;
        qb.push_back(mk(1'b1, 2'd3, 2'd1));
        drive(); drain();

        // sustained contention alternates A,B,A,B
        fixed_delay = 0;
        qa.push_back(mk(1'b0, 2'd3, 2'd0));
        qa.push_back(mk(1'b1, 2'd0, 2'd2));
        qb.push_back(mk(1'b0, 2'd1, 2'd0));
        qb.push_back(mk(1'b0, 2'd0, 2'd0));
        drive(); drain();

        // async reset while mem_req is pending
        evict(2);
        fixed_delay = 20;
        qa.push_back(mk(1'b0, 2'd2, 2'd0));
        drive();
        n = 0;
        while (!mem_req && n < 50) begin @(negedge clk); n++; end
        check("mem_req_before_reset", mem_req, 1);
        a_valid = 1'b1; a_rw = 1'b0; a_addr = 2'd0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_mem_req", mem_req, 0);
        check("abort_resp_valid", resp_valid, 0);
        check("abort_a_ready", a_ready, 0);
        check("abort_b_ready", b_ready, 0);
        check("abort_miss_cnt", miss_cnt, 0);
        exp_q.delete();
        m_misses = 0;
        m_last = PORT_B;
        seen[2] = 1'b0;
        a_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        fixed_delay = 1;
        qa.push_back(mk(1'b0, 2'd2, 2'd0));
        drive(); drain();

        // randomized traffic with random evictions and memory delays
        rand_delay = 1'b1;
        for (int it = 0; it < 40; it++) begin
            for (int k = 0; k < 4; k++) if ($urandom_range(0, 3) == 0) evict(k);
            repeat ($urandom_range(0, 2)) qa.push_back(rand_req());
            repeat ($urandom_range(0, 2)) qb.push_back(rand_req());
            drive(); drain();
        end

        // miss counter saturation
        rand_delay = 1'b0;
        fixed_delay = 0;
        for (int i = 0; i < 300; i++) begin
            evict(0);
            qa.push_back(mk(1'b0, 2'd0, 2'd0));
            drive(); drain();
        end
        check("miss_saturated", miss_cnt, 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
